// File: rtl/pe_noc_tx.sv
// pe_noc_tx: PE-side enable/ready NoC transmitter for one PE input channel.
// Words from the GLB side are buffered in a DEPTH-entry FIFO, then streamed
// to the PE as a burst of L words. Each word is held on noc_data, with
// noc_enable set, until the PE returns noc_ready.
// Optional build macro: NOC_TX_ZERO_IDLE_EN. When it is defined, noc_data
// reads zero whenever noc_enable is low. When it is undefined, noc_data
// keeps the last word that was sent.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; the FIFO may still be prefetched
// SEND   | loading words into the output register and counting transfers
// DONE   | one-cycle completion pulse, then back to IDLE
module pe_noc_tx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              start,
    input  logic [3:0]        burst_len,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] noc_data,
    output logic              noc_enable,
    input  logic              noc_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [1:0]        state;
    logic [4:0]        len;
    logic [4:0]        issued;
    logic [4:0]        sent;
    logic              full;
    logic              empty;
    logic              push;
    logic              load;
    logic              xfer;

    // wr_ready comes only from the registered count. A pop in the same cycle
    // therefore does not open the FIFO early, and there is no path from
    // noc_ready to wr_ready.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign xfer     = noc_enable && noc_ready;
    assign load     = (state == S_SEND) && !empty && (issued < len) &&
                      (!noc_enable || noc_ready);
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE);

    // FIFO storage; it is not reset because valid data is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and occupancy; a pop is exactly an output-register load
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, load})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Burst sequencing: latch the length, count issued and sent words
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            len    <= '0;
            issued <= '0;
            sent   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len    <= (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                        issued <= '0;
                        sent   <= '0;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (load) issued <= issued + 5'd1;
                    if (xfer) begin
                        sent <= sent + 5'd1;
                        if (sent + 5'd1 == len) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: it is held under backpressure, reloaded on
    // transfer-with-load, and emptied on transfer-without-load
    always_ff @(posedge clk) begin
        if (rst) begin
            noc_data   <= '0;
            noc_enable <= 1'b0;
        end else if (load) begin
            noc_data   <= mem[rd_ptr];
            noc_enable <= 1'b1;
        end else if (xfer) begin
            noc_enable <= 1'b0;
`ifdef NOC_TX_ZERO_IDLE_EN
            noc_data   <= '0;
`else
            noc_data   <= noc_data;
`endif
        end
    end
endmodule

// File: tb/tb_pe_noc_tx.sv
// Directed self-checking bench for pe_noc_tx (DATA_W=8, DEPTH=4).
module tb_pe_noc_tx;
    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       start;
    logic [3:0] burst_len;
    logic       done;
    logic       busy;
    logic [7:0] noc_data;
    logic       noc_enable;
    logic       noc_ready;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    int dones  = 0;
    logic [7:0] got_q[$];

    pe_noc_tx #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .start(start), .burst_len(burst_len),
        .done(done), .busy(busy), .noc_data(noc_data),
        .noc_enable(noc_enable), .noc_ready(noc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record the transfer the coming edge will perform, then advance to #1 past it
    task automatic step();
        if (noc_enable && noc_ready && !rst) begin
            xfers++;
            got_q.push_back(noc_data);
        end
        @(posedge clk);
        #1;
        if (done) dones++;
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int g;
        int d0;
        rst = 1'b1; wr_data = '0; wr_valid = 1'b0; start = 1'b0;
        burst_len = '0; noc_ready = 1'b1;
        step();
        check("rst_enable",   32'(noc_enable), 0);
        check("rst_data",     32'(noc_data),   0);
        check("rst_done",     32'(done),       0);
        check("rst_busy",     32'(busy),       0);
        check("rst_wr_ready", 32'(wr_ready),   1);
        rst = 1'b0;

        // Prefetch 1, -2, 3 and send them as a three-word burst
        push_word(8'd1); push_word(8'hFE); push_word(8'd3);
        dones = 0;
        start = 1'b1; burst_len = 4'd3; step(); start = 1'b0;
        check("t1_busy",   32'(busy), 1);
        check("t1_en0",    32'(noc_enable), 0);
        step();
        check("t1_en1",    32'(noc_enable), 1);
        check("t1_w0",     32'(noc_data), 32'h01);
        step();
        check("t1_w1",     32'(noc_data), 32'hFE);
        step();
        check("t1_w2",     32'(noc_data), 32'h03);
        step();
        check("t1_en_off", 32'(noc_enable), 0);
        check("t1_done",   32'(done), 1);
        step();
        check("t1_done_off", 32'(done), 0);
        check("t1_idle",     32'(busy), 0);
        check("t1_one_done", 32'(dones), 1);

        // Fill the FIFO, stall the 5th word, and release it with a burst
        wr_valid = 1'b1;
        wr_data = 8'h10; step();
        wr_data = 8'h11; step();
        wr_data = 8'h12; step();
        wr_data = 8'h13; step();
        check("t2_full", 32'(wr_ready), 0);
        wr_data = 8'h14; step();
        check("t2_stall", 32'(wr_ready), 0);
        start = 1'b1; burst_len = 4'd2; step(); start = 1'b0;
        check("t2_still_full", 32'(wr_ready), 0);
        step();
        check("t2_ready_after_pop", 32'(wr_ready), 1);
        check("t2_w0", 32'(noc_data), 32'h10);
        step();
        wr_valid = 1'b0;
        check("t2_w1", 32'(noc_data), 32'h11);
        step();
        check("t2_done", 32'(done), 1);
        check("t2_en_off", 32'(noc_enable), 0);
        step();
        start = 1'b1; burst_len = 4'd3; step(); start = 1'b0;
        step();
        check("t2_b2_w0", 32'(noc_data), 32'h12);
        step();
        check("t2_b2_w1", 32'(noc_data), 32'h13);
        step();
        check("t2_b2_w2", 32'(noc_data), 32'h14);
        step();
        check("t2_b2_done", 32'(done), 1);
        step();

        // Backpressure pattern 0,0,1,0,1 on a two-word burst
        push_word(8'h21); push_word(8'h22);
        xfers = 0;
        noc_ready = 1'b0;
        start = 1'b1; burst_len = 4'd2; step(); start = 1'b0;
        step();
        check("t3_load", 32'(noc_data), 32'h21);
        check("t3_en",   32'(noc_enable), 1);
        noc_ready = 1'b0; step();
        check("t3_hold_a", 32'(noc_data), 32'h21);
        check("t3_hold_a_en", 32'(noc_enable), 1);
        noc_ready = 1'b0; step();
        check("t3_hold_b", 32'(noc_data), 32'h21);
        noc_ready = 1'b1; step();
        check("t3_next", 32'(noc_data), 32'h22);
        noc_ready = 1'b0; step();
        check("t3_hold_c", 32'(noc_data), 32'h22);
        check("t3_no_done", 32'(done), 0);
        noc_ready = 1'b1; step();
        check("t3_done",  32'(done), 1);
        check("t3_xfers", 32'(xfers), 2);
        step();

        // burst_len=0 means 16 words, fed from an empty FIFO
        xfers = 0; dones = 0; got_q.delete();
        start = 1'b1; burst_len = 4'd0; step(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'h40 + i);
            wr_valid = 1'b1;
            g = 0;
            while (!wr_ready && g < 20) begin step(); g++; end
            step();
        end
        wr_valid = 1'b0;
        g = 0;
        while (busy && g < 40) begin step(); g++; end
        check("t4_timeout", 32'(busy), 0);
        check("t4_xfers",   32'(xfers), 16);
        check("t4_dones",   32'(dones), 1);
        check("t4_qsize",   32'(got_q.size()), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check("t4_word", 32'(got_q[i]), 32'(8'h40 + i));

        // Reset after one of four transfers
        push_word(8'h51); push_word(8'h52); push_word(8'h53); push_word(8'h54);
        start = 1'b1; burst_len = 4'd4; step(); start = 1'b0;
        step();
        step();
        d0 = dones;
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_en",   32'(noc_enable), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        start = 1'b1; burst_len = 4'd1; step(); start = 1'b0;
        step(); step();
        check("t5_empty_en", 32'(noc_enable), 0);
        check("t5_waiting",  32'(busy), 1);
        push_word(8'h60);
        check("t5_no_bypass", 32'(noc_enable), 0);
        step();
        check("t5_en_rise", 32'(noc_enable), 1);
        check("t5_data",    32'(noc_data), 32'h60);
        step();
        check("t5_done_new", 32'(done), 1);
        check("t5_one_done", 32'(dones - d0), 1);
        step();
        check("t5_idle", 32'(busy), 0);

        // burst_len=1 timing and the idle value of noc_data after sending 7
        push_word(8'h07);
        start = 1'b1; burst_len = 4'd1; step(); start = 1'b0;
        step();
        check("t6_en",   32'(noc_enable), 1);
        check("t6_data", 32'(noc_data), 32'h07);
        step();
        check("t6_en_off", 32'(noc_enable), 0);
        check("t6_done",   32'(done), 1);
`ifdef NOC_TX_ZERO_IDLE_EN
        check("t6_idle_data", 32'(noc_data), 32'h00);
`else
        check("t6_idle_data", 32'(noc_data), 32'h07);
`endif
        step();
        check("t6_idle", 32'(busy), 0);
        check("t6_done_off", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
